// File: rtl/lut_wvf_loader_pkg.sv
// lut_wvf_loader_pkg: loader FSM encoding and LUT address width helper
package lut_wvf_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_t;

    // Address width for an n-entry LUT, shared with the waveform generator
    function automatic int lut_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_wvf_loader.sv
// lut_wvf_loader: fills a shadow LUT over valid/ready and commits it atomically to LUT_ROM
//   CLK_SYS, nRST             clock, async active-low reset
//   EN, START                 enable (low aborts), load request
//   DATA_IN/VALID/READY       sample stream, entry 0 first
//   LUT_END_IN                generator end-of-waveform, the commit window
//   LUT_ROM                   active waveform, entry i at [i*BIT_WIDTH +: BIT_WIDTH]
//   WR_ADDR, LOAD_BUSY, LOAD_DONE  status
module lut_wvf_loader
    import lut_wvf_loader_pkg::*;
#(
    parameter int LUT_WIDTH   = 32,
    parameter int BIT_WIDTH   = 16,
    parameter bit SYNC_COMMIT = 1
) (
    input  logic                            CLK_SYS,
    input  logic                            nRST,
    input  logic                            EN,
    input  logic                            START,
    input  logic [BIT_WIDTH-1:0]            DATA_IN,
    input  logic                            DATA_VALID,
    output logic                            DATA_READY,
    input  logic                            LUT_END_IN,
    output logic [BIT_WIDTH*LUT_WIDTH-1:0]  LUT_ROM,
    output logic [lut_addr_w(LUT_WIDTH)-1:0] WR_ADDR,
    output logic                            LOAD_BUSY,
    output logic                            LOAD_DONE
);

    localparam int AW = lut_addr_w(LUT_WIDTH);

    state_t state, state_nx;
    logic [BIT_WIDTH-1:0] shadow [LUT_WIDTH];
    logic xfer, last, commit;

    always_comb begin
        xfer       = EN && state == LOAD && DATA_VALID;
        last       = xfer && WR_ADDR == AW'(LUT_WIDTH - 1);
        // EN low blocks the commit so an abort never touches LUT_ROM
        commit     = EN && state == PEND && (!SYNC_COMMIT || LUT_END_IN);
        DATA_READY = state == LOAD;
        LOAD_BUSY  = state != IDLE;
        LOAD_DONE  = commit;
        state_nx   = state;
        if (!EN)
            state_nx = IDLE;
        else if (state == IDLE)
            state_nx = START ? LOAD : IDLE;
        else if (state == LOAD)
            state_nx = last ? PEND : LOAD;
        else if (state == PEND)
            state_nx = commit ? (START ? LOAD : IDLE) : PEND;
        else
            state_nx = IDLE;
    end

    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            WR_ADDR <= '0;
        end else begin
            state   <= state_nx;
            WR_ADDR <= (!EN || last || (state == IDLE && START)) ? '0 :
                       xfer ? WR_ADDR + 1'b1 : WR_ADDR;
        end
    end

    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < LUT_WIDTH; i++) shadow[i] <= '0;
            LUT_ROM <= '0;
        end else begin
            if (xfer) shadow[WR_ADDR] <= DATA_IN;
            if (commit)
                for (int i = 0; i < LUT_WIDTH; i++) LUT_ROM[i*BIT_WIDTH +: BIT_WIDTH] <= shadow[i];
        end
    end

endmodule

// File: tb/tb_lut_wvf_loader.sv
// tb_lut_wvf_loader: scoreboard bench for lut_wvf_loader, immediate and synchronised commit
module tb_lut_wvf_loader;

    logic        CLK_SYS = 0;
    logic        nRST = 0;
    logic        EN = 0;
    logic        START = 0;
    logic [7:0]  DATA_IN = 0;
    logic        DATA_VALID = 0;
    logic        LUT_END_IN = 0;
    logic        ready0, ready1, busy0, busy1, done0, done1;
    logic [31:0] rom0, rom1;
    logic [1:0]  addr0, addr1;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic pend0 = 0;
    logic pend1 = 0;

    always #5 CLK_SYS = ~CLK_SYS;

    lut_wvf_loader #(.LUT_WIDTH(4), .BIT_WIDTH(8), .SYNC_COMMIT(0)) u0 (
        .CLK_SYS(CLK_SYS), .nRST(nRST), .EN(EN), .START(START), .DATA_IN(DATA_IN),
        .DATA_VALID(DATA_VALID), .DATA_READY(ready0), .LUT_END_IN(LUT_END_IN),
        .LUT_ROM(rom0), .WR_ADDR(addr0), .LOAD_BUSY(busy0), .LOAD_DONE(done0));

    lut_wvf_loader #(.LUT_WIDTH(4), .BIT_WIDTH(8), .SYNC_COMMIT(1)) u1 (
        .CLK_SYS(CLK_SYS), .nRST(nRST), .EN(EN), .START(START), .DATA_IN(DATA_IN),
        .DATA_VALID(DATA_VALID), .DATA_READY(ready1), .LUT_END_IN(LUT_END_IN),
        .LUT_ROM(rom1), .WR_ADDR(addr1), .LOAD_BUSY(busy1), .LOAD_DONE(done1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // A LOAD_DONE seen in one cycle means LUT_ROM must hold the next queued image one cycle later
    always @(negedge CLK_SYS) begin
        if (pend0) begin
            if (q0.size() == 0) check("unexp_done0", 1, 0);
            else check("sb_rom0", rom0, q0.pop_front());
            check("sb_addr0", {30'd0, addr0}, 0);
        end
        if (pend1) begin
            if (q1.size() == 0) check("unexp_done1", 1, 0);
            else check("sb_rom1", rom1, q1.pop_front());
            check("sb_addr1", {30'd0, addr1}, 0);
        end
        pend0 <= done0;
        pend1 <= done1;
    end

    task automatic tick();
        @(posedge CLK_SYS);
        #1;
    endtask

    task automatic start_load();
        START = 1;
        tick();
        START = 0;
    endtask

    task automatic send_word(input logic [7:0] d);
        DATA_IN = d;
        DATA_VALID = 1;
        @(negedge CLK_SYS);
        check("ready0", {31'd0, ready0}, 1);
        check("ready1", {31'd0, ready1}, 1);
        tick();
        DATA_VALID = 0;
    endtask

    task automatic load4(input logic [31:0] img, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_word(img[i*8 +: 8]);
            if (gap && i < 3) begin
                @(negedge CLK_SYS);
                check("gap_addr", {30'd0, addr0}, i + 1);
                tick();
            end
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_rom0", rom0, 0);
        check("rst_rom1", rom1, 0);
        check("rst_ready", {31'd0, ready0 | ready1}, 0);
        check("rst_busy", {31'd0, busy0 | busy1}, 0);
        check("rst_done", {31'd0, done0 | done1}, 0);
        check("rst_addr", {30'd0, addr0 | addr1}, 0);
        nRST = 1;
        EN = 1;
        LUT_END_IN = 1;
        tick();

        // back-to-back load, commit in the first PEND cycle on both instances
        q0.push_back(32'h44332211);
        q1.push_back(32'h44332211);
        start_load();
        load4(32'h44332211, 0);
        @(negedge CLK_SYS);
        check("t1_done0", {31'd0, done0}, 1);
        check("t1_done1", {31'd0, done1}, 1);
        tick();
        check("t1_rom", rom0, 32'h44332211);
        check("t1_busy", {31'd0, busy0}, 0);
        check("t1_done_off", {31'd0, done0}, 0);

        // valid toggling: only valid beats are written
        q0.push_back(32'h88776655);
        q1.push_back(32'h88776655);
        start_load();
        load4(32'h88776655, 1);
        tick();
        check("t2_rom0", rom0, 32'h88776655);
        check("t2_rom1", rom1, 32'h88776655);

        // synchronised commit waits for LUT_END_IN
        LUT_END_IN = 0;
        q0.push_back(32'hA4A3A2A1);
        q1.push_back(32'hA4A3A2A1);
        start_load();
        load4(32'hA4A3A2A1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK_SYS);
            check("t3_busy1", {31'd0, busy1}, 1);
            check("t3_hold1", rom1, 32'h88776655);
            check("t3_nodone1", {31'd0, done1}, 0);
            tick();
        end
        check("t3_rom0", rom0, 32'hA4A3A2A1);
        LUT_END_IN = 1;
        @(negedge CLK_SYS);
        check("t3_done1", {31'd0, done1}, 1);
        tick();
        LUT_END_IN = 0;
        check("t3_rom1", rom1, 32'hA4A3A2A1);
        check("t3_idle1", {31'd0, busy1}, 0);

        // abort after two words
        LUT_END_IN = 1;
        start_load();
        send_word(8'hC1);
        send_word(8'hC2);
        EN = 0;
        @(negedge CLK_SYS);
        check("t4_nodone", {31'd0, done0 | done1}, 0);
        tick();
        EN = 1;
        check("t4_addr", {30'd0, addr0 | addr1}, 0);
        check("t4_busy", {31'd0, busy0 | busy1}, 0);
        check("t4_ready", {31'd0, ready0 | ready1}, 0);
        check("t4_rom", rom0, 32'hA4A3A2A1);
        tick();
        q0.push_back(32'hD4D3D2D1);
        q1.push_back(32'hD4D3D2D1);
        start_load();
        load4(32'hD4D3D2D1, 0);
        tick();
        check("t4_reload", rom1, 32'hD4D3D2D1);

        // valid in IDLE is ignored; START in LOAD is ignored
        DATA_IN = 8'hEE;
        DATA_VALID = 1;
        @(negedge CLK_SYS);
        check("t6_idle_ready", {31'd0, ready0}, 0);
        tick();
        check("t6_idle_addr", {30'd0, addr0}, 0);
        DATA_VALID = 0;
        q0.push_back(32'hB4B3B2B1);
        q1.push_back(32'hB4B3B2B1);
        start_load();
        send_word(8'hB1);
        START = 1;
        tick();
        START = 0;
        check("t6_start_ign", {30'd0, addr0}, 1);
        send_word(8'hB2);
        send_word(8'hB3);
        send_word(8'hB4);
        // START coinciding with LOAD_DONE begins a fresh load
        START = 1;
        @(negedge CLK_SYS);
        check("t6_done", {31'd0, done0}, 1);
        tick();
        START = 0;
        check("t6_reload_busy", {31'd0, busy0 & busy1}, 1);
        check("t6_reload_ready", {31'd0, ready0}, 1);
        check("t6_reload_addr", {30'd0, addr0}, 0);
        check("t6_rom", rom0, 32'hB4B3B2B1);
        q0.push_back(32'hE4E3E2E1);
        q1.push_back(32'hE4E3E2E1);
        load4(32'hE4E3E2E1, 0);
        tick();

        // async reset while u1 waits in PEND
        LUT_END_IN = 0;
        q0.push_back(32'hF4F3F2F1);
        start_load();
        load4(32'hF4F3F2F1, 0);
        tick();
        tick();
        check("t5_pend", {31'd0, busy1}, 1);
        #2;
        nRST = 0;
        #1;
        check("t5_rom0", rom0, 0);
        check("t5_rom1", rom1, 0);
        check("t5_busy", {31'd0, busy0 | busy1}, 0);
        check("t5_ready", {31'd0, ready0 | ready1}, 0);
        repeat (3) tick();
        nRST = 1;
        tick();
        check("t5_idle", {31'd0, busy1}, 0);
        check("t5_addr", {30'd0, addr1}, 0);

        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
